queue_uart_tx: RTL



---
 rtl/queue_uart_tx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/queue_uart_tx.sv
// Serial transmitter draining a first-word fall-through queue.
// Frames: start, LSB-first data, optional even parity, stop.
module queue_uart_tx #(
  parameter int Width    = 8,
  parameter bit ParityEn = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] q_data,
  input  logic             q_void,
  output logic             q_pull,
  output logic             sout,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CW-1:0] LAST = CW'(Width - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [Width-1:0] shreg;
  logic [Width-1:0] shreg_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic             par;
  logic             par_n;
  logic             sout_n;
  logic             done_n;
  logic             take;

  // A word is taken only where a new frame may begin.
  assign take   = en & ~q_void &
                  ((state == IDLE) | (state == STOP));
  assign q_pull = ~rst & take;
  assign busy   = (state != IDLE);

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    par_n   = par;
    sout_n  = sout;
    done_n  = 1'b0;
    if (en) begin
      unique case (1'b1)
        (state == IDLE): begin
          if (!q_void) begin
            shreg_n = q_data;
            par_n   = ^q_data;
            sout_n  = 1'b0;
            state_n = START;
          end else begin
            sout_n  = 1'b1;
          end
        end
        (state == START): begin
          sout_n  = shreg[0];
          shreg_n = shreg >> 1;
          cnt_n   = '0;
          state_n = DATA;
        end
        (state == DATA): begin
          if (cnt == LAST) begin
            if (ParityEn) begin
              sout_n  = par;
              state_n = PARITY;
            end else begin
              sout_n  = 1'b1;
              state_n = STOP;
            end
          end else begin
            sout_n  = shreg[0];
            shreg_n = shreg >> 1;
            cnt_n   = cnt + CW'(1);
          end
        end
        (state == PARITY): begin
          sout_n  = 1'b1;
          state_n = STOP;
        end
        (state == STOP): begin
          done_n = 1'b1;
          // Reload straight from the stop bit: no idle gap.
          if (!q_void) begin
            shreg_n = q_data;
            par_n   = ^q_data;
            sout_n  = 1'b0;
            state_n = START;
          end else begin
            sout_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          sout_n  = 1'b1;
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      sout      <= 1'b1;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      par       <= par_n;
      sout      <= sout_n;
      word_done <= done_n;
    end
  end

endmodule
